obi_shared_mem_responder: RTL and testbench

// - OBI responder (slave end) serving NPORTS initiator ports from one shared single-port word memory.
// - Targets the dual-core ext CPU system: each core's instr/data port maps onto one responder port.
// - Per-cycle round-robin arbitration, one access per cycle, in-order responses per port.

---
 rtl/obi_shared_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_obi_shared_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_shared_mem_responder.sv
// OBI responder serving NPORTS initiators from one shared single-port word memory.
// Round-robin arbitration, one access per cycle, read/write response one cycle
// after the grant edge.
// Optional build macro OBI_SHARED_MEM_RESP_PIPE_EN adds an output register stage
// (response two cycles after the grant edge); writes still commit at the grant edge.

package obi_shared_mem_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module obi_shared_mem_responder
   import obi_shared_mem_pkg::*;
#(
   parameter int          NPORTS    = 2,
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'hF001_0000,
   parameter logic [31:0] OOR_RDATA = 32'hBADC_AB1E
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  obi_req_t  [NPORTS-1:0] req_i,
   output obi_resp_t [NPORTS-1:0] resp_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     gnt_idx;
   logic [PW-1:0]     cand;
   logic              any_gnt;
   logic [NPORTS-1:0] gnt_vec;

   obi_req_t          sel;
   logic [31:0]       off;
   logic              in_range;
   logic [AW-1:0]     word_idx;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       rd_mem;

   logic [NPORTS-1:0] rv1;
   logic              wr1;
   logic              oor1;
   logic [31:0]       rdata1;

   logic [NPORTS-1:0] out_rv;
   logic [31:0]       out_rdata;

   // Round-robin pick: first requesting port at or after rr_ptr, wrapping.
   always_comb begin
      gnt_vec = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      cand    = '0;
      for (int i = 0; i < NPORTS; i++) begin
         cand = PW'((int'(rr_ptr) + i) % NPORTS);
         if (!any_gnt && req_i[cand].req) begin
            any_gnt       = 1'b1;
            gnt_idx       = cand;
            gnt_vec[cand] = 1'b1;
         end
      end
   end

   // Decode the granted request; the 64-bit compare avoids wrap at the top of the map.
   always_comb begin
      sel      = req_i[gnt_idx];
      off      = sel.addr - BASE_ADDR;
      in_range = (sel.addr >= BASE_ADDR) && ({32'd0, off} < (64'(DEPTH) * 64'd4));
      word_idx = off[2 +: AW];
   end

   // Memory array: byte-masked write or full-word read at the grant edge, no reset.
   always_ff @(posedge clk_i) begin
      if (any_gnt && in_range) begin
         if (sel.we) begin
            for (int b = 0; b < 4; b++) begin
               if (sel.be[b]) begin
                  mem[word_idx][8*b +: 8] <= sel.wdata[8*b +: 8];
               end
            end
         end else begin
            rd_mem <= mem[word_idx];
         end
      end
   end

   // Arbitration pointer and first response stage bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
         rv1    <= '0;
         wr1    <= 1'b0;
         oor1   <= 1'b0;
      end else begin
         rv1  <= gnt_vec;
         wr1  <= sel.we;
         oor1 <= !in_range;
         if (any_gnt) begin
            if (int'(gnt_idx) == NPORTS - 1) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= gnt_idx + 1'b1;
            end
         end
      end
   end

   // Writes answer with zero, out-of-range reads with the poison word.
   always_comb begin
      if (wr1) begin
         rdata1 = '0;
      end else if (oor1) begin
         rdata1 = OOR_RDATA;
      end else begin
         rdata1 = rd_mem;
      end
   end

`ifdef OBI_SHARED_MEM_RESP_PIPE_EN
   logic [NPORTS-1:0] rv2;
   logic [31:0]       rdata2;

   // Extra output register stage for timing; ordering is unaffected.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rv2    <= '0;
         rdata2 <= '0;
      end else begin
         rv2    <= rv1;
         rdata2 <= rdata1;
      end
   end

   assign out_rv    = rv2;
   assign out_rdata = rdata2;
`else
   assign out_rv    = rv1;
   assign out_rdata = rdata1;
`endif

   // Pack responses; rdata is forced to zero outside its rvalid cycle.
   always_comb begin
      for (int k = 0; k < NPORTS; k++) begin
         resp_o[k].gnt    = gnt_vec[k];
         resp_o[k].rvalid = out_rv[k];
         resp_o[k].rdata  = out_rv[k] ? out_rdata : 32'h0;
      end
   end

endmodule

// File: tb/tb_obi_shared_mem_responder.sv
// Directed bench for obi_shared_mem_responder (2 ports, 4096 words).
// Response latency follows OBI_SHARED_MEM_RESP_PIPE_EN.

module tb_obi_shared_mem_responder;
   import obi_shared_mem_pkg::*;

`ifdef OBI_SHARED_MEM_RESP_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam logic [31:0] BASE = 32'hF001_0000;
   localparam logic [31:0] OOR  = 32'hBADC_AB1E;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   obi_req_t  [1:0]  req;
   obi_resp_t [1:0]  resp;
   int               n_chk = 0;
   int               n_err = 0;
   logic [31:0]      rd;
   int               lat;

   obi_shared_mem_responder #(
      .NPORTS    (2),
      .DEPTH     (4096),
      .BASE_ADDR (BASE),
      .OOR_RDATA (OOR)
   ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req),
      .resp_o (resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int p, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req[p].req   = 1'b1;
      req[p].we    = we;
      req[p].be    = be;
      req[p].addr  = addr;
      req[p].wdata = wdata;
   endtask

   task automatic idle(input int p);
      req[p] = '0;
   endtask

   // Called just after a grant edge; waits a bounded number of cycles for rvalid.
   task automatic wait_resp(input int p, output logic [31:0] data, output int l);
      l    = 0;
      data = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp[p].rvalid) begin
            l    = i + 1;
            data = resp[p].rdata;
            break;
         end
      end
   endtask

   task automatic access(input int p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data);
      int l;
      @(posedge clk); #1;
      drive(p, we, be, addr, wdata);
      @(negedge clk);
      chk("acc_gnt", resp[p].gnt, 1'b1);
      @(posedge clk); #1;
      idle(p);
      wait_resp(p, data, l);
      chk("acc_latency", l, LAT);
      @(negedge clk);
      chk("acc_rvalid_one_cycle", resp[p].rvalid, 1'b0);
   endtask

   // Both ports read for four cycles; grants alternate from port 0.
   task automatic run_contention();
      int   w;
      logic e0, e1;
      @(posedge clk); #1;
      drive(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
      drive(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
      for (int c = 0; c < 5 + LAT; c++) begin
         @(negedge clk);
         chk("cont_gnt0", resp[0].gnt, (c < 4) && (c % 2 == 0));
         chk("cont_gnt1", resp[1].gnt, (c < 4) && (c % 2 == 1));
         w  = c - LAT;
         e0 = (w >= 0) && (w < 4) && (w % 2 == 0);
         e1 = (w >= 0) && (w < 4) && (w % 2 == 1);
         chk("cont_rv0", resp[0].rvalid, e0);
         chk("cont_rv1", resp[1].rvalid, e1);
         chk("cont_rd0", resp[0].rdata, e0 ? 32'h1234_5678 : 32'h0);
         chk("cont_rd1", resp[1].rdata, e1 ? 32'hAA22_CC44 : 32'h0);
         @(posedge clk); #1;
         if (c == 3) begin
            idle(0);
            idle(1);
         end
      end
   endtask

   initial begin
      req = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt0", resp[0].gnt, 1'b0);
      chk("rst_gnt1", resp[1].gnt, 1'b0);
      chk("rst_rv0", resp[0].rvalid, 1'b0);
      chk("rst_rv1", resp[1].rvalid, 1'b0);
      chk("rst_rd0", resp[0].rdata, 32'h0);
      chk("rst_rd1", resp[1].rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      access(0, 1'b1, 4'hF, BASE + 32'h10, 32'h1234_5678, rd);
      chk("wr_rdata_zero", rd, 32'h0);
      access(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, rd);
      chk("rd_basic", rd, 32'h1234_5678);

      access(1, 1'b1, 4'hF, BASE + 32'h20, 32'hAABB_CCDD, rd);
      access(1, 1'b1, 4'b0101, BASE + 32'h20, 32'h1122_3344, rd);
      chk("be_wr_rdata_zero", rd, 32'h0);
      access(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0, rd);
      chk("be_merge", rd, 32'hAA22_CC44);
      access(0, 1'b0, 4'h0, BASE + 32'h23, 32'h0, rd);
      chk("addr_lsb_be_ignored", rd, 32'hAA22_CC44);

      access(0, 1'b1, 4'hF, BASE, 32'h0102_0304, rd);
      access(0, 1'b1, 4'hF, BASE + 32'h3FFC, 32'h5A5A_0001, rd);
      access(1, 1'b0, 4'hF, BASE + 32'h3FFC, 32'h0, rd);
      chk("last_word", rd, 32'h5A5A_0001);
      access(0, 1'b0, 4'hF, BASE + 32'h4000, 32'h0, rd);
      chk("oor_high", rd, OOR);
      access(1, 1'b0, 4'hF, BASE - 32'h4, 32'h0, rd);
      chk("oor_low", rd, OOR);
      access(0, 1'b1, 4'hF, BASE + 32'h4000, 32'hDEAD_BEEF, rd);
      chk("oor_wr_rdata_zero", rd, 32'h0);
      access(0, 1'b0, 4'hF, BASE, 32'h0, rd);
      chk("oor_wr_dropped", rd, 32'h0102_0304);
      access(0, 1'b1, 4'hF, BASE + 32'h40, 32'h0, rd);

      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_contention();

      // Pointer is 0 after contention: port 0 write first, port 1 read next cycle.
      @(posedge clk); #1;
      drive(0, 1'b1, 4'hF, BASE + 32'h40, 32'hCAFE_F00D);
      drive(1, 1'b0, 4'hF, BASE + 32'h40, 32'h0);
      @(negedge clk);
      chk("raw_gnt0", resp[0].gnt, 1'b1);
      chk("raw_gnt1_wait", resp[1].gnt, 1'b0);
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      chk("raw_gnt1", resp[1].gnt, 1'b1);
      @(posedge clk); #1;
      idle(1);
      wait_resp(1, rd, lat);
      chk("raw_latency", lat, LAT);
      chk("raw_data", rd, 32'hCAFE_F00D);

      // Grant port 0 so the pointer moves to 1, then reset right after a read grant.
      access(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, rd);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
      @(negedge clk);
      chk("midrst_gnt", resp[0].gnt, 1'b1);
      @(posedge clk); #1;
      idle(0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_rv0_in_rst", resp[0].rvalid, 1'b0);
         chk("midrst_rv1_in_rst", resp[1].rvalid, 1'b0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_late_rv0", resp[0].rvalid, 1'b0);
         chk("midrst_no_late_rv1", resp[1].rvalid, 1'b0);
      end
      run_contention();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
